// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control block: FSM encoding and default widths.
package pipe_ctrl_pkg;

  localparam int REG_ADDR_W_DEF = 5;
  localparam int CNT_W_DEF      = 16;

  typedef enum logic [1:0] {
    BOOT      = 2'd0,
    RUN       = 2'd1,
    IMEM_WAIT = 2'd2,
    REDIRECT  = 2'd3
  } state_t;

endpackage

// File: rtl/pipe_ctrl_sat_cnt.sv
// Saturating event counter with synchronous clear and increment enable.
module sat_cnt
  import pipe_ctrl_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Holds at all-ones instead of wrapping so long stalls never read as short ones.
  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: fetch stall, load-use interlock and branch/jump redirect sequencing.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  imem_ready,
  input  logic                  idu_valid,
  input  logic                  idu_rs1_used,
  input  logic                  idu_rs2_used,
  input  logic [REG_ADDR_W-1:0] idu_rs1,
  input  logic [REG_ADDR_W-1:0] idu_rs2,
  input  logic                  exu_load,
  input  logic [REG_ADDR_W-1:0] exu_rd,
  input  logic                  exu2ifu_branch_en,
  input  logic                  exu2ifu_jump_en,
  output logic                  pc_hold,
  output logic                  ifu2idu_en,
  output logic                  ifu2idu_flush,
  output logic                  idu2exu_bubble,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  state_t state;
  state_t next_state;
  logic   redirect;
  logic   load_use;
  logic   stall_inc;

  assign redirect = exu2ifu_branch_en | exu2ifu_jump_en;

  // x0 is hardwired zero, so a load targeting it can never create a hazard.
  assign load_use = idu_valid & exu_load & (exu_rd != '0) &
                    ((idu_rs1_used & (idu_rs1 == exu_rd)) |
                     (idu_rs2_used & (idu_rs2 == exu_rd)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state     = state;
    pc_hold        = 1'b0;
    ifu2idu_en     = 1'b0;
    ifu2idu_flush  = 1'b0;
    idu2exu_bubble = 1'b0;
    if (rst) begin
      pc_hold    = 1'b1;
      next_state = BOOT;
    end else begin
      unique case (state)
        BOOT: begin
          pc_hold    = 1'b1;
          next_state = RUN;
        end
        RUN, IMEM_WAIT: begin
          if (redirect) begin
            ifu2idu_flush  = 1'b1;
            idu2exu_bubble = 1'b1;
            next_state     = REDIRECT;
          end else if (load_use) begin
            // An outstanding fetch in IMEM_WAIT keeps waiting; the bubble goes in regardless.
            pc_hold        = 1'b1;
            idu2exu_bubble = 1'b1;
            next_state     = ((state == IMEM_WAIT) && !imem_ready) ? IMEM_WAIT : RUN;
          end else if (!imem_ready) begin
            pc_hold    = 1'b1;
            next_state = IMEM_WAIT;
          end else begin
            ifu2idu_en = 1'b1;
            next_state = RUN;
          end
        end
        REDIRECT: begin
          if (redirect) begin
            ifu2idu_flush  = 1'b1;
            idu2exu_bubble = 1'b1;
            next_state     = REDIRECT;
          end else begin
            next_state = RUN;
          end
        end
        default: begin
          pc_hold    = 1'b1;
          next_state = BOOT;
        end
      endcase
    end
  end

  assign stall_inc = pc_hold & (state != BOOT);

  sat_cnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_cnt #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (ifu2idu_flush),
    .count (flush_cnt)
  );

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: REG_ADDR_W, default 5, register-index width.
REQ-002 Parameter: CNT_W, default 16, performance-counter width.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 imem_ready  in  1  instruction memory returned the word for the previous request.
REQ-007 idu_valid  in  1  IF/ID register holds a live instruction (ifu2idu_en_r).
REQ-008 idu_rs1_used, idu_rs2_used  in  1 each  decoded instruction reads rs1/rs2.
REQ-009 idu_rs1, idu_rs2  in  REG_ADDR_W each  source register indices.
REQ-010 exu_load  in  1  EXU holds a valid load.
REQ-011 exu_rd  in  REG_ADDR_W  destination of the EXU instruction.
REQ-012 exu2ifu_branch_en, exu2ifu_jump_en  in  1 each  taken branch / jump redirect.
REQ-013 pc_hold  out  1  IFU keeps the current PC.
REQ-014 ifu2idu_en  out  1  IF/ID capture enable.
REQ-015 ifu2idu_flush  out  1  clear IF/ID.
REQ-016 idu2exu_bubble  out  1  load a NOP into ID/EX.
REQ-017 stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Function
REQ-018 FSM states: BOOT, RUN, IMEM_WAIT, REDIRECT; state register only; decode outputs combinationally from state and inputs.
REQ-019 BOOT: entered on reset; lasts exactly one cycle; pc_hold=1, ifu2idu_en=0; always -> RUN.
REQ-020 redirect = exu2ifu_branch_en | exu2ifu_jump_en; highest priority in RUN and IMEM_WAIT.
REQ-021 redirect cycle: ifu2idu_flush=1, idu2exu_bubble=1, ifu2idu_en=0, pc_hold=0; next state REDIRECT.
REQ-022 REDIRECT: lasts one cycle; ifu2idu_en=0 (discards word fetched from the stale PC), pc_hold=0; -> RUN, or stays REDIRECT if redirect reasserts.
REQ-023 load_use = idu_valid & exu_load & (exu_rd != 0) & ((idu_rs1_used & idu_rs1==exu_rd) | (idu_rs2_used & idu_rs2==exu_rd)).
REQ-024 RUN with load_use and no redirect: pc_hold=1, ifu2idu_en=0 (IF/ID holds), idu2exu_bubble=1; state stays RUN; hazard clears the next cycle as the load leaves EXU.
REQ-025 RUN with imem_ready=0, no redirect, no load_use: pc_hold=1, ifu2idu_en=0; next state IMEM_WAIT.
REQ-026 IMEM_WAIT: pc_hold=1, ifu2idu_en=0 until imem_ready=1; on imem_ready=1, ifu2idu_en=1, pc_hold=0, -> RUN (load_use in the same cycle still forces pc_hold=1, ifu2idu_en=0, bubble=1, -> RUN).
REQ-027 RUN with no event: pc_hold=0, ifu2idu_en=1, flush/bubble=0.
REQ-028 Priority per cycle: reset > redirect > load_use > imem wait > normal.
REQ-029 stall_cnt +1 each cycle pc_hold=1 outside BOOT; flush_cnt +1 each redirect cycle; both saturate at all-ones, never wrap.
REQ-030 ifu2idu_flush and ifu2idu_en are never both 1.

Reset
REQ-031 rst=1 at a clock edge: state=BOOT, stall_cnt=0, flush_cnt=0, regardless of state or in-flight events.
REQ-032 Outputs during rst=1 cycles: pc_hold=1, ifu2idu_en=0, ifu2idu_flush=0, idu2exu_bubble=0.
REQ-033 Reset mid-IMEM_WAIT or mid-REDIRECT discards the pending condition; no carry-over.

Structure
REQ-034 Shared package: FSM state encoding (2-bit), REG_ADDR_W default, CNT_W default.
REQ-035 One sub-module: sat_cnt (CNT_W saturating counter, synchronous clear, increment enable), instantiated twice.
REQ-036 Hazard compare is inline combinational logic; no extra pipeline stage.

Verification
REQ-037 Reset 3 cycles, release: cycle 1 pc_hold=1, ifu2idu_en=0; cycle 2 ifu2idu_en=1, pc_hold=0.
REQ-038 exu_load=1, exu_rd=5, idu_valid=1, idu_rs2_used=1, idu_rs2=5 for one cycle -> pc_hold=1, bubble=1, ifu2idu_en=0 that cycle; stall_cnt=1; exu_rd=0 same case -> no stall.
REQ-039 exu2ifu_branch_en=1 coincident with load_use and imem_ready=0 -> ifu2idu_flush=1, bubble=1, pc_hold=0; next cycle REDIRECT with ifu2idu_en=0; flush_cnt=1.
REQ-040 imem_ready=0 for 4 cycles in RUN -> pc_hold=1 for 4 cycles, ifu2idu_en=1 on the ready cycle; stall_cnt=4.
REQ-041 CNT_W=4, hold imem_ready=0 for 20 cycles -> stall_cnt stops at 15.
REQ-042 rst=1 asserted in IMEM_WAIT with stall_cnt=7 -> next cycle state BOOT, stall_cnt=0.
